// File: rtl/override_monitor.sv
// Override monitor: flags episodes where obs departs from src, with glitch filter.
// Optional OVR_GLITCH_CNT_EN adds a saturating count of filtered glitches.
module override_monitor #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int MIN_LEN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] obs,
  output logic             active,
  output logic             start_pulse,
  output logic             end_pulse,
  output logic [WIDTH-1:0] ovr_val,
  output logic [CNT_W-1:0] ovr_len,
`ifdef OVR_GLITCH_CNT_EN
  output logic [CNT_W-1:0] glitch_cnt,
`endif
  output logic [CNT_W-1:0] episode_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX   = '1;
  localparam logic [CNT_W:0]   MIN_L = (CNT_W+1)'(MIN_LEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic             active_q, active_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [CNT_W-1:0] olen_q, olen_d;
  logic [CNT_W-1:0] epi_q, epi_d;
`ifdef OVR_GLITCH_CNT_EN
  logic [CNT_W-1:0] gl_q, gl_d;
`endif

  logic m;
  logic pend_done;

  assign m         = (src != obs);
  assign pend_done = (({1'b0, run_q} + (CNT_W+1)'(1)) == MIN_L);

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    len_d    = len_q;
    cand_d   = cand_q;
    active_d = active_q;
    start_d  = 1'b0;
    end_d    = 1'b0;
    val_d    = val_q;
    olen_d   = olen_q;
    epi_d    = epi_q;
`ifdef OVR_GLITCH_CNT_EN
    gl_d     = gl_q;
`endif
    if (clr) begin
      state_d  = IDLE;
      run_d    = '0;
      len_d    = '0;
      cand_d   = '0;
      active_d = 1'b0;
      val_d    = '0;
      olen_d   = '0;
      epi_d    = '0;
`ifdef OVR_GLITCH_CNT_EN
      gl_d     = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (m) begin
            if (MIN_LEN == 1) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
              start_d  = 1'b1;
              val_d    = obs;
              len_d    = CNT_W'(1);
            end else begin
              state_d = PEND;
              run_d   = CNT_W'(1);
              cand_d  = obs;
            end
          end
        end
        PEND: begin
          if (!m) begin
            state_d = IDLE;
`ifdef OVR_GLITCH_CNT_EN
            if (gl_q != MAX) gl_d = gl_q + CNT_W'(1);
`endif
          end else if (pend_done) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
            start_d  = 1'b1;
            val_d    = cand_q;
            len_d    = CNT_W'(MIN_LEN);
          end else begin
            run_d = run_q + CNT_W'(1);
          end
        end
        ACTIVE: begin
          if (m) begin
            if (len_q != MAX) len_d = len_q + CNT_W'(1);
          end else begin
            state_d  = IDLE;
            active_d = 1'b0;
            end_d    = 1'b1;
            olen_d   = len_q;
            if (epi_q != MAX) epi_d = epi_q + CNT_W'(1);
          end
        end
        default: begin
          state_d  = IDLE;
          active_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      run_q    <= '0;
      len_q    <= '0;
      cand_q   <= '0;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      val_q    <= '0;
      olen_q   <= '0;
      epi_q    <= '0;
`ifdef OVR_GLITCH_CNT_EN
      gl_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      len_q    <= len_d;
      cand_q   <= cand_d;
      active_q <= active_d;
      start_q  <= start_d;
      end_q    <= end_d;
      val_q    <= val_d;
      olen_q   <= olen_d;
      epi_q    <= epi_d;
`ifdef OVR_GLITCH_CNT_EN
      gl_q     <= gl_d;
`endif
    end
  end

  assign active      = active_q;
  assign start_pulse = start_q;
  assign end_pulse   = end_q;
  assign ovr_val     = val_q;
  assign ovr_len     = olen_q;
  assign episode_cnt = epi_q;
`ifdef OVR_GLITCH_CNT_EN
  assign glitch_cnt  = gl_q;
`endif

endmodule

// File: tb/tb_override_monitor.sv
// Directed bench for override_monitor (WIDTH=4, CNT_W=4, MIN_LEN=2).
// Expected values are hand-derived per scenario.
module tb_override_monitor;
  localparam int W  = 4;
  localparam int CW = 4;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  src = '0;
  logic [W-1:0]  obs = '0;
  logic          active;
  logic          start_pulse;
  logic          end_pulse;
  logic [W-1:0]  ovr_val;
  logic [CW-1:0] ovr_len;
  logic [CW-1:0] episode_cnt;
`ifdef OVR_GLITCH_CNT_EN
  logic [CW-1:0] glitch_cnt;
`endif

  int n_chk = 0;
  int n_bad = 0;
  logic seen;

  override_monitor #(
    .WIDTH(W),
    .CNT_W(CW),
    .MIN_LEN(ML)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .src(src),
    .obs(obs),
    .active(active),
    .start_pulse(start_pulse),
    .end_pulse(end_pulse),
    .ovr_val(ovr_val),
    .ovr_len(ovr_len),
`ifdef OVR_GLITCH_CNT_EN
    .glitch_cnt(glitch_cnt),
`endif
    .episode_cnt(episode_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // reset state while rst_n is low
    #3;
    chk("rst_active", int'(active), 0);
    chk("rst_start", int'(start_pulse), 0);
    chk("rst_end", int'(end_pulse), 0);
    chk("rst_val", int'(ovr_val), 0);
    chk("rst_len", int'(ovr_len), 0);
    chk("rst_epi", int'(episode_cnt), 0);
    #9;
    rst_n = 1'b1;

    // basic episode
    src = 4'd2;
    obs = 4'd2;
    ticks(2);
    chk("b_idle", int'(active), 0);
    obs = 4'd14;
    tick();
    chk("b_e1_start", int'(start_pulse), 0);
    chk("b_e1_active", int'(active), 0);
    tick();
    chk("b_e2_start", int'(start_pulse), 1);
    chk("b_e2_active", int'(active), 1);
    chk("b_e2_val", int'(ovr_val), 14);
    for (int i = 3; i <= 9; i++) begin
      src = (i <= 3) ? 4'd2 : (i <= 6) ? 4'd6 : 4'd8;
      tick();
      if (i == 3) chk("b_e3_start", int'(start_pulse), 0);
    end
    chk("b_e9_active", int'(active), 1);
    chk("b_e9_end", int'(end_pulse), 0);
    obs = 4'd8;
    tick();
    chk("b_end", int'(end_pulse), 1);
    chk("b_end_active", int'(active), 0);
    chk("b_len", int'(ovr_len), 9);
    chk("b_epi", int'(episode_cnt), 1);
    chk("b_val", int'(ovr_val), 14);
    tick();
    chk("b_end_once", int'(end_pulse), 0);

    // glitch filter
    src = 4'd4;
    obs = 4'd7;
    seen = 1'b0;
    tick();
    seen = seen | start_pulse | end_pulse;
    obs = 4'd4;
    tick();
    seen = seen | start_pulse | end_pulse;
    tick();
    seen = seen | start_pulse | end_pulse | active;
    chk("g_pulses", int'(seen), 0);
    chk("g_epi", int'(episode_cnt), 1);
    chk("g_val", int'(ovr_val), 14);
`ifdef OVR_GLITCH_CNT_EN
    chk("g_cnt", int'(glitch_cnt), 1);
`endif

    // saturation
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("c_epi", int'(episode_cnt), 0);
    chk("c_len", int'(ovr_len), 0);
    chk("c_val", int'(ovr_val), 0);
`ifdef OVR_GLITCH_CNT_EN
    chk("c_gl", int'(glitch_cnt), 0);
`endif
    src = 4'd1;
    obs = 4'd9;
    ticks(20);
    obs = 4'd1;
    tick();
    chk("s_long_end", int'(end_pulse), 1);
    chk("s_long_len", int'(ovr_len), 15);
    chk("s_long_epi", int'(episode_cnt), 1);
    for (int i = 0; i < 17; i++) begin
      obs = 4'd9;
      ticks(3);
      obs = 4'd1;
      tick();
      if (i == 12) chk("s_epi14", int'(episode_cnt), 14);
    end
    chk("s_epi_sat", int'(episode_cnt), 15);
    chk("s_len3", int'(ovr_len), 3);

    // invisible override
    clr = 1'b1;
    tick();
    clr = 1'b0;
    src = 4'd5;
    obs = 4'd5;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen = seen | active | start_pulse | end_pulse;
    end
    chk("i_quiet", int'(seen), 0);

    // reset mid-episode
    src = 4'd3;
    obs = 4'd10;
    ticks(3);
    obs = 4'd3;
    tick();
    chk("r_pre_epi", int'(episode_cnt), 1);
    obs = 4'd10;
    ticks(4);
    chk("r_pre_active", int'(active), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("r_active", int'(active), 0);
    chk("r_val", int'(ovr_val), 0);
    chk("r_len", int'(ovr_len), 0);
    chk("r_epi", int'(episode_cnt), 0);
    #2;
    obs = 4'd3;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen = seen | end_pulse;
    end
    chk("r_no_end", int'(seen), 0);

    // clr on the end edge
    src = 4'd3;
    obs = 4'd11;
    ticks(3);
    chk("k_active", int'(active), 1);
    obs = 4'd3;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("k_end", int'(end_pulse), 0);
    chk("k_active0", int'(active), 0);
    chk("k_epi", int'(episode_cnt), 0);
    chk("k_len", int'(ovr_len), 0);
    chk("k_val", int'(ovr_val), 0);
    tick();
    chk("k_end_after", int'(end_pulse), 0);
    obs = 4'd12;
    tick();
    chk("k_idle_e1", int'(start_pulse), 0);
    tick();
    chk("k_idle_e2", int'(start_pulse), 1);
    chk("k_idle_val", int'(ovr_val), 12);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
